// File: rtl/video_timing_sched_if.sv
// Pixel stream handshake between the upstream line buffer and the
// video timing scheduler.
interface video_timing_sched_if;
   logic [23:0] pix_data;
   logic        pix_valid;
   logic        pix_ready;

   modport master (
      output pix_data,
      output pix_valid,
      input  pix_ready
   );

   modport slave (
      input  pix_data,
      input  pix_valid,
      output pix_ready
   );
endinterface

// File: rtl/video_timing_sched.sv
// HDMI raster timing generator with pixel pull, prefetch and underflow flag.
// Optional colour-bar source: define VIDEO_TIMING_SCHED_TEST_PATTERN_EN.
module video_timing_sched #(
   parameter int H_ACTIVE = 1280,
   parameter int H_FP     = 110,
   parameter int H_SYNC   = 40,
   parameter int H_BP     = 220,
   parameter int V_ACTIVE = 720,
   parameter int V_FP     = 5,
   parameter int V_SYNC   = 5,
   parameter int V_BP     = 20,
   parameter bit HS_POL   = 1'b1,
   parameter bit VS_POL   = 1'b1,
   parameter int PREFETCH = 64
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        en,
   video_timing_sched_if.slave         pix,
   output logic                        line_req,
   output logic [11:0]                 line_y,
   output logic                        frame_start,
   output logic [23:0]                 rgb_out,
   output logic                        hsync_out,
   output logic                        vsync_out,
   output logic                        de_out,
   output logic                        busy,
   output logic                        underflow,
   input  logic                        underflow_clr,
   input  logic                        pattern_sel
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
   localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
   localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
   localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
   localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
   localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [11:0] VS_BEG = 12'(V_ACTIVE + V_FP);
   localparam logic [11:0] VS_END = 12'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [11:0] H_REQ  = 12'(H_TOTAL - PREFETCH);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

   state_e      state_q, state_d;
   logic [11:0] h_cnt_q, h_cnt_d;
   logic [11:0] v_cnt_q, v_cnt_d;
   logic [23:0] rgb_q, rgb_d;
   logic        de_q, de_d;
   logic        hs_q, hs_d;
   logic        vs_q, vs_d;
   logic        uf_q, uf_d;

   logic        h_last, v_last, active, pat_on;
   logic [11:0] v_next;
   logic [23:0] bar_rgb;

`ifdef VIDEO_TIMING_SCHED_TEST_PATTERN_EN
   localparam int BAR_W = (H_ACTIVE / 8 < 1) ? 1 : H_ACTIVE / 8;
   logic [2:0] bar_idx;

   assign bar_idx = 3'(h_cnt_q / 12'(BAR_W));
   assign pat_on  = pattern_sel;

   always_comb begin
      bar_rgb = 24'h000000;
      case (bar_idx)
         3'd0: bar_rgb = 24'hFFFFFF;
         3'd1: bar_rgb = 24'hFFFF00;
         3'd2: bar_rgb = 24'h00FFFF;
         3'd3: bar_rgb = 24'h00FF00;
         3'd4: bar_rgb = 24'hFF00FF;
         3'd5: bar_rgb = 24'hFF0000;
         3'd6: bar_rgb = 24'h0000FF;
         default: bar_rgb = 24'h000000;
      endcase
   end
`else
   logic unused_pattern_sel;

   assign unused_pattern_sel = pattern_sel;
   assign pat_on  = 1'b0;
   assign bar_rgb = 24'h000000;
`endif

   assign h_last = (h_cnt_q == H_LAST);
   assign v_last = (v_cnt_q == V_LAST);
   assign v_next = v_last ? 12'd0 : v_cnt_q + 12'd1;
   assign busy   = (state_q != IDLE);
   assign active = busy && (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);

   assign pix.pix_ready = active && !pat_on;
   assign frame_start   = (state_q == RUN) &&
                          (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
   assign line_req      = (state_q == RUN) &&
                          (h_cnt_q == H_REQ) && (v_next < V_ACT);
   assign line_y        = v_next;

   always_comb begin
      state_d = state_q;
      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
      unique case (state_q)
         IDLE:  if (en) state_d = RUN;
         RUN:   if (!en) state_d = DRAIN;
         DRAIN: begin
            if (en) state_d = RUN;
            else if (h_last && v_last) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (state_q == IDLE) begin
         h_cnt_d = 12'd0;
         v_cnt_d = 12'd0;
      end else if (h_last) begin
         h_cnt_d = 12'd0;
         v_cnt_d = v_next;
      end else begin
         h_cnt_d = h_cnt_q + 12'd1;
      end
   end

   // Registered outputs carry the counter cycle one clock later.
   always_comb begin
      de_d = active;
      hs_d = (busy && h_cnt_q >= HS_BEG && h_cnt_q < HS_END) ?
             HS_POL : !HS_POL;
      vs_d = (busy && v_cnt_q >= VS_BEG && v_cnt_q < VS_END) ?
             VS_POL : !VS_POL;
      rgb_d = 24'h000000;
      if (active) begin
         if (pat_on) rgb_d = bar_rgb;
         else if (pix.pix_valid) rgb_d = pix.pix_data;
      end
      uf_d = (pix.pix_ready && !pix.pix_valid) ||
             (uf_q && !underflow_clr);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         h_cnt_q <= 12'd0;
         v_cnt_q <= 12'd0;
         rgb_q   <= 24'h000000;
         de_q    <= 1'b0;
         hs_q    <= !HS_POL;
         vs_q    <= !VS_POL;
         uf_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
         rgb_q   <= rgb_d;
         de_q    <= de_d;
         hs_q    <= hs_d;
         vs_q    <= vs_d;
         uf_q    <= uf_d;
      end
   end

   assign rgb_out   = rgb_q;
   assign de_out    = de_q;
   assign hsync_out = hs_q;
   assign vsync_out = vs_q;
   assign underflow = uf_q;

endmodule

// File: tb/tb_video_timing_sched.sv
// Directed bench for video_timing_sched on a 16x8 raster (128-cycle frame).
module tb_video_timing_sched;

   logic        clk = 1'b0;
   logic        rst, en, underflow_clr, pattern_sel;
   logic        line_req, frame_start;
   logic [11:0] line_y;
   logic [23:0] rgb_out;
   logic        hsync_out, vsync_out, de_out, busy, underflow;

   int vectors = 0;
   int errors  = 0;
   int cyc     = 0;

   video_timing_sched_if pif ();

   video_timing_sched #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .HS_POL(1'b1), .VS_POL(1'b1), .PREFETCH(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .en(en),
      .pix(pif.slave),
      .line_req(line_req),
      .line_y(line_y),
      .frame_start(frame_start),
      .rgb_out(rgb_out),
      .hsync_out(hsync_out),
      .vsync_out(vsync_out),
      .de_out(de_out),
      .busy(busy),
      .underflow(underflow),
      .underflow_clr(underflow_clr),
      .pattern_sel(pattern_sel)
   );

   always #5 clk = ~clk;

   function automatic logic [23:0] f(int c);
      return 24'(c + 'h100);
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s @cyc %0d: got %0h expected %0h",
                tag, cyc, obs, exp);
      end
   endtask

   // Advance to the next counter cycle; drive that cycle's pixel.
   task automatic step();
      @(negedge clk);
      cyc = cyc + 1;
      pif.pix_data = f(cyc);
   endtask

   task automatic step_to(int c);
      while (cyc < c) step();
   endtask

   task automatic restart();
      rst = 1'b1;
      step();
      rst = 1'b0;
      en  = 1'b1;
      cyc = -1;
      step();
   endtask

   logic [23:0] bars [8];

   initial begin
      int h, v, p, ph, pv, nv;
      logic e_de, e_lr;

      bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
      rst = 1'b1; en = 1'b0; underflow_clr = 1'b0; pattern_sel = 1'b0;
      pif.pix_valid = 1'b1; pif.pix_data = '0;
      step(); step();

      chk("rst_de",    32'(de_out),       0);
      chk("rst_hs",    32'(hsync_out),    0);
      chk("rst_vs",    32'(vsync_out),    0);
      chk("rst_rgb",   32'(rgb_out),      0);
      chk("rst_busy",  32'(busy),         0);
      chk("rst_uf",    32'(underflow),    0);
      chk("rst_ready", 32'(pif.pix_ready), 0);
      chk("rst_lreq",  32'(line_req),     0);
      chk("rst_fs",    32'(frame_start),  0);

      // Basic timing over two full frames
      rst = 1'b0; en = 1'b1; cyc = -1;
      for (int c = 0; c < 256; c++) begin
         step();
         h = c % 16; v = (c / 16) % 8;
         p = c - 1; ph = p % 16; pv = (p / 16) % 8;
         nv = (v + 1) % 8;
         e_de = (c > 0) && ph < 8 && pv < 4;
         e_lr = (h == 12) && (nv < 4);
         chk("fs",    32'(frame_start), 32'(h == 0 && v == 0));
         chk("ready", 32'(pif.pix_ready), 32'(h < 8 && v < 4));
         chk("lreq",  32'(line_req), 32'(e_lr));
         if (e_lr) chk("line_y", 32'(line_y), 32'(nv));
         chk("de",    32'(de_out), 32'(e_de));
         chk("hs",    32'(hsync_out),
             32'((c > 0) && ph >= 10 && ph < 13));
         chk("vs",    32'(vsync_out),
             32'((c > 0) && pv >= 5 && pv < 7));
         chk("rgb",   32'(rgb_out), e_de ? 32'(f(p)) : 32'd0);
         chk("busy",  32'(busy), 1);
      end

      // Underflow on 3rd pixel of line 1
      step_to(274);
      pif.pix_valid = 1'b0;
      step();
      pif.pix_valid = 1'b1;
      chk("uf_rgb0", 32'(rgb_out), 0);
      chk("uf_de",   32'(de_out), 1);
      chk("uf_set",  32'(underflow), 1);
      step();
      chk("uf_rgb1", 32'(rgb_out), 32'(f(275)));
      chk("uf_stky", 32'(underflow), 1);
      step_to(277);
      pif.pix_valid = 1'b0; underflow_clr = 1'b1;
      step();
      pif.pix_valid = 1'b1; underflow_clr = 1'b0;
      chk("uf_win",  32'(underflow), 1);
      chk("uf_rgb2", 32'(rgb_out), 0);
      step_to(282);
      chk("uf_hold", 32'(underflow), 1);
      underflow_clr = 1'b1;
      step();
      underflow_clr = 1'b0;
      chk("uf_clr",  32'(underflow), 0);

      // Stop on frame boundary
      restart();
      step_to(40);
      en = 1'b0;
      step_to(44);
      chk("dr_lreq",  32'(line_req), 0);
      step_to(48);
      chk("dr_ready", 32'(pif.pix_ready), 1);
      step();
      chk("dr_de",    32'(de_out), 1);
      chk("dr_rgb",   32'(rgb_out), 32'(f(48)));
      step_to(124);
      chk("dr_lreq0", 32'(line_req), 0);
      step_to(127);
      chk("dr_busy",  32'(busy), 1);
      step();
      chk("st_busy",  32'(busy), 0);
      chk("st_ready", 32'(pif.pix_ready), 0);
      chk("st_fs",    32'(frame_start), 0);
      step();
      chk("st_de",    32'(de_out), 0);
      chk("st_hs",    32'(hsync_out), 0);
      chk("st_vs",    32'(vsync_out), 0);
      chk("st_rgb",   32'(rgb_out), 0);
      step_to(140);
      chk("st_idle",  32'(busy), 0);

      // Stop then resume mid-frame
      restart();
      step_to(40);
      en = 1'b0;
      step_to(44);
      chk("rr_lreq",  32'(line_req), 0);
      step_to(60);
      en = 1'b1;
      chk("rr_busy",  32'(busy), 1);
      step_to(124);
      chk("rr_lreq7", 32'(line_req), 1);
      chk("rr_ly7",   32'(line_y), 0);
      step_to(128);
      chk("rr_fs",    32'(frame_start), 1);
      chk("rr_busy2", 32'(busy), 1);
      step();
      chk("rr_de",    32'(de_out), 1);
      chk("rr_rgb",   32'(rgb_out), 32'(f(128)));
      step_to(140);
      chk("rr_lreq0", 32'(line_req), 1);
      chk("rr_ly0",   32'(line_y), 1);

      // Reset mid-frame with en held high
      restart();
      step_to(70);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mr_de",    32'(de_out), 0);
      chk("mr_hs",    32'(hsync_out), 0);
      chk("mr_vs",    32'(vsync_out), 0);
      chk("mr_busy",  32'(busy), 0);
      chk("mr_ready", 32'(pif.pix_ready), 0);
      step();
      chk("mr_fs",    32'(frame_start), 1);
      chk("mr_rdy2",  32'(pif.pix_ready), 1);
      step();
      chk("mr_de2",   32'(de_out), 1);
      chk("mr_rgb",   32'(rgb_out), 32'(f(72)));

      // Test pattern select
      pattern_sel = 1'b1;
`ifdef VIDEO_TIMING_SCHED_TEST_PATTERN_EN
      pif.pix_valid = 1'b0;
      restart();
      for (int c = 0; c < 9; c++) begin
         if (c > 0) step();
         if (c < 8) chk("tp_ready", 32'(pif.pix_ready), 0);
         if (c > 0) begin
            chk("tp_rgb", 32'(rgb_out), 32'(bars[c-1]));
            chk("tp_de",  32'(de_out), 1);
         end
      end
      chk("tp_uf", 32'(underflow), 0);
`else
      restart();
      chk("np_ready", 32'(pif.pix_ready), 1);
      step();
      chk("np_rgb",   32'(rgb_out), 32'(f(0)));
      chk("np_bar",   32'(rgb_out == bars[0]), 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, errors);
      $finish;
   end

endmodule
